// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator controller and divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package calc_pkg;

  localparam int DIGITS   = 4;
  localparam int OP_W     = 14;
  localparam int RES_W    = 27;
  localparam int CNT_W    = $clog2(DIGITS + 1);
  localparam int MAX_OPND = 9999;

  localparam logic [3:0] KEY_DIV = 4'd10;
  localparam logic [3:0] KEY_CLR = 4'd11;
  localparam logic [3:0] KEY_ADD = 4'd12;
  localparam logic [3:0] KEY_SUB = 4'd13;
  localparam logic [3:0] KEY_MUL = 4'd14;
  localparam logic [3:0] KEY_EQ  = 4'd15;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_t;

  typedef enum logic [2:0] {
    ENTER_A = 3'd0,
    ENTER_B = 3'd1,
    EXEC    = 3'd2,
    DIV     = 3'd3,
    SHOW    = 3'd4,
    ERR     = 3'd5
  } state_t;

  // Decimal shift-in of one digit; callers guarantee the result fits.
  function automatic logic [OP_W-1:0] digit_append(input logic [OP_W-1:0] x,
                                                   input logic [3:0] d);
    logic [OP_W-1:0] r;
    r = x * OP_W'(10) + {{(OP_W-4){1'b0}}, d};
    return r;
  endfunction

  function automatic logic is_op_key(input logic [3:0] k);
    return (k == KEY_DIV) || (k == KEY_ADD) || (k == KEY_SUB) || (k == KEY_MUL);
  endfunction

  function automatic op_t op_of_key(input logic [3:0] k);
    op_t o;
    case (k)
      KEY_SUB: o = OP_SUB;
      KEY_MUL: o = OP_MUL;
      KEY_DIV: o = OP_DIV;
      default: o = OP_ADD;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/calc_ctrl_if.sv
// Key-event input and display/status outputs of the calculator controller.
// Latency: n/a (wiring only).
// Backpressure: none; keys arriving while busy are dropped by the controller.
interface calc_ctrl_if;
  import calc_pkg::*;

  logic [3:0]       key_val;
  logic             key_pressed;
  logic [RES_W-1:0] disp_val;
  logic             disp_neg;
  logic [1:0]       op_code;
  logic             op_valid;
  logic             busy;
  logic             err;

  modport master (
    output key_val, key_pressed,
    input  disp_val, disp_neg, op_code, op_valid, busy, err
  );

  modport slave (
    input  key_val, key_pressed,
    output disp_val, disp_neg, op_code, op_valid, busy, err
  );

endinterface

// File: rtl/calc_div.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Latency: done pulses exactly OP_W cycles after start; quotient valid with done.
// Backpressure: none; start is accepted whenever given, abort returns to idle.
module calc_div
  import calc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [OP_W-1:0] dividend,
  input  logic [OP_W-1:0] divisor,
  output logic [OP_W-1:0] quotient,
  output logic            done
);

  localparam int DC_W = $clog2(OP_W + 1);

  logic [OP_W-1:0] rem;
  logic [OP_W-1:0] quo;
  logic [OP_W-1:0] dvs;
  logic [DC_W-1:0] cnt;

  logic [OP_W-1:0] rem_src, quo_src, dvs_src;
  logic [OP_W:0]   rem_sh, diff;
  logic            ge;
  logic [OP_W-1:0] rem_nxt, quo_nxt;

  // One restoring step; on start the step runs on the freshly loaded operands.
  always_comb begin
    rem_src = start ? '0 : rem;
    quo_src = start ? dividend : quo;
    dvs_src = start ? divisor : dvs;
    rem_sh  = {rem_src, quo_src[OP_W-1]};
    diff    = rem_sh - {1'b0, dvs_src};
    ge      = ~diff[OP_W];
    rem_nxt = ge ? diff[OP_W-1:0] : rem_sh[OP_W-1:0];
    quo_nxt = {quo_src[OP_W-2:0], ge};
  end

  // Iteration counter and datapath registers; done is a registered single pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
      cnt  <= '0;
      done <= 1'b0;
    end else if (abort) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (start) begin
      rem  <= rem_nxt;
      quo  <= quo_nxt;
      dvs  <= divisor;
      cnt  <= DC_W'(OP_W - 1);
      done <= 1'b0;
    end else if (cnt != '0) begin
      rem  <= rem_nxt;
      quo  <= quo_nxt;
      cnt  <= cnt - 1'b1;
      done <= (cnt == DC_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  assign quotient = quo;

endmodule

// File: rtl/calc_ctrl.sv
// Calculator sequencer: operand/operator entry, one-cycle +,-,* and multi-cycle /.
// Latency: outputs reflect a key one cycle after key_pressed; / takes 1+OP_W cycles.
// Backpressure: none; non-clear keys during EXEC/DIV are dropped, not queued.
module calc_ctrl
  import calc_pkg::*;
(
  input logic        clk,
  input logic        rst,
  calc_ctrl_if.slave bus
);

  state_t           state;
  logic [OP_W-1:0]  a, b;
  logic [CNT_W-1:0] a_cnt, b_cnt;
  op_t              op_code;
  logic             op_valid, busy, err;
  logic [RES_W-1:0] disp_val;
  logic             disp_neg;

  logic [3:0]       key;
  logic             key_clr, key_dig, key_op, key_eq;
  logic [OP_W-1:0]  a_dig, b_dig, mag;
  logic [RES_W-1:0] sum, prod;
  logic [OP_W-1:0]  quotient;
  logic             div_start, div_abort, div_done;

  assign key     = bus.key_val;
  assign key_clr = bus.key_pressed && (key == KEY_CLR);
  assign key_dig = bus.key_pressed && (key < 4'd10);
  assign key_op  = bus.key_pressed && is_op_key(key);
  assign key_eq  = bus.key_pressed && (key == KEY_EQ);

  assign a_dig = digit_append(a, key);
  assign b_dig = digit_append(b, key);
  assign mag   = (a >= b) ? (a - b) : (b - a);
  assign sum   = RES_W'(a) + RES_W'(b);
  assign prod  = RES_W'(a) * RES_W'(b);

  // Divider is kicked from EXEC only for a non-zero divisor; clear always aborts it.
  assign div_start = (state == EXEC) && (op_code == OP_DIV) && (b != '0) && !key_clr;
  assign div_abort = key_clr;

  calc_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .abort    (div_abort),
    .dividend (a),
    .divisor  (b),
    .quotient (quotient),
    .done     (div_done)
  );

  // Main sequencer: clear has priority over every other transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || key_clr) begin
      state    <= ENTER_A;
      a        <= '0;
      b        <= '0;
      a_cnt    <= '0;
      b_cnt    <= '0;
      op_code  <= OP_ADD;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
      disp_val <= '0;
      disp_neg <= 1'b0;
    end else begin
      case (state)
        ENTER_A: begin
          if (key_dig && (a_cnt < CNT_W'(DIGITS))) begin
            a        <= a_dig;
            a_cnt    <= a_cnt + 1'b1;
            disp_val <= RES_W'(a_dig);
          end else if (key_op) begin
            op_code  <= op_of_key(key);
            op_valid <= 1'b1;
            b        <= '0;
            b_cnt    <= '0;
            state    <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (key_dig && (b_cnt < CNT_W'(DIGITS))) begin
            b        <= b_dig;
            b_cnt    <= b_cnt + 1'b1;
            disp_val <= RES_W'(b_dig);
          end else if (key_op && (b_cnt == '0)) begin
            op_code <= op_of_key(key);
          end else if (key_eq && (b_cnt != '0)) begin
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          case (op_code)
            OP_ADD: begin
              disp_val <= sum;
              disp_neg <= 1'b0;
            end
            OP_SUB: begin
              disp_val <= RES_W'(mag);
              disp_neg <= (a < b);
            end
            OP_MUL: begin
              disp_val <= prod;
              disp_neg <= 1'b0;
            end
            default: ;
          endcase
          if (op_code != OP_DIV) begin
            busy     <= 1'b0;
            op_valid <= 1'b0;
            state    <= SHOW;
          end else if (b == '0) begin
            busy     <= 1'b0;
            op_valid <= 1'b0;
            err      <= 1'b1;
            disp_val <= '0;
            disp_neg <= 1'b0;
            state    <= ERR;
          end else begin
            state <= DIV;
          end
        end
        DIV: begin
          if (div_done) begin
            disp_val <= RES_W'(quotient);
            disp_neg <= 1'b0;
            busy     <= 1'b0;
            op_valid <= 1'b0;
            state    <= SHOW;
          end
        end
        SHOW: begin
          if (key_dig) begin
            a        <= {{(OP_W-4){1'b0}}, key};
            a_cnt    <= CNT_W'(1);
            b        <= '0;
            b_cnt    <= '0;
            op_code  <= OP_ADD;
            disp_val <= RES_W'(key);
            disp_neg <= 1'b0;
            state    <= ENTER_A;
          end else if (key_op && !disp_neg && (disp_val <= RES_W'(MAX_OPND))) begin
            a        <= disp_val[OP_W-1:0];
            a_cnt    <= CNT_W'(DIGITS);
            b        <= '0;
            b_cnt    <= '0;
            op_code  <= op_of_key(key);
            op_valid <= 1'b1;
            state    <= ENTER_B;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.disp_val = disp_val;
  assign bus.disp_neg = disp_neg;
  assign bus.op_code  = op_code;
  assign bus.op_valid = op_valid;
  assign bus.busy     = busy;
  assign bus.err      = err;

endmodule

// File: tb/tb_calc_ctrl.sv
// Directed-vector bench for calc_ctrl with hand-computed expectations.
// Latency: keys driven on falling edges, outputs sampled on falling edges.
// Backpressure: n/a.
module tb_calc_ctrl;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   n_busy;

  always #5 clk = ~clk;

  calc_ctrl_if bus();

  calc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] dv, input logic neg,
                            input logic [1:0] opc, input logic opv, input logic bsy,
                            input logic er);
    check({tag, ".disp_val"}, 32'(bus.disp_val), dv);
    check({tag, ".disp_neg"}, 32'(bus.disp_neg), 32'(neg));
    check({tag, ".op_code"},  32'(bus.op_code),  32'(opc));
    check({tag, ".op_valid"}, 32'(bus.op_valid), 32'(opv));
    check({tag, ".busy"},     32'(bus.busy),     32'(bsy));
    check({tag, ".err"},      32'(bus.err),      32'(er));
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_val     = k;
    bus.key_pressed = 1'b1;
    @(negedge clk);
    bus.key_pressed = 1'b0;
  endtask

  // Counts falling edges with busy high, bounded so a stuck busy still ends the run.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.key_val     = 4'd0;
    bus.key_pressed = 1'b0;
    repeat (2) @(negedge clk);
    check_outs("reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // 12 + 34 = 46
    press(4'd1); press(4'd2);
    check("t1.a", 32'(bus.disp_val), 12);
    press(KEY_ADD);
    check_outs("t1.op", 12, 0, 0, 1, 0, 0);
    press(4'd3); press(4'd4);
    check("t1.b", 32'(bus.disp_val), 34);
    press(KEY_EQ);
    count_busy(n_busy);
    check("t1.busy_cycles", 32'(n_busy), 1);
    check_outs("t1.res", 46, 0, 0, 0, 0, 0);

    // 5 - 9 = -4, then an operator on a negative result is ignored
    press(4'd5);
    check_outs("t2.a", 5, 0, 0, 0, 0, 0);
    press(KEY_SUB); press(4'd9); press(KEY_EQ);
    count_busy(n_busy);
    check_outs("t2.res", 4, 1, 1, 0, 0, 0);
    press(KEY_ADD);
    check_outs("t2.ign_op", 4, 1, 1, 0, 0, 0);

    // 9999 * 9999 with the fifth digit dropped
    repeat (5) press(4'd9);
    check_outs("t3.a", 9999, 0, 0, 0, 0, 0);
    press(KEY_MUL);
    check("t3.op_code", 32'(bus.op_code), 2);
    repeat (4) press(4'd9);
    press(KEY_EQ);
    count_busy(n_busy);
    check_outs("t3.res", 99980001, 0, 2, 0, 0, 0);

    // 100 / 7 = 14, then chain + 2 = 16
    press(4'd1); press(4'd0); press(4'd0);
    check("t4.a", 32'(bus.disp_val), 100);
    press(KEY_DIV); press(4'd7); press(KEY_EQ);
    count_busy(n_busy);
    check("t4.busy_cycles", 32'(n_busy), 15);
    check_outs("t4.res", 14, 0, 3, 0, 0, 0);
    press(KEY_ADD);
    check_outs("t4.chain_op", 14, 0, 0, 1, 0, 0);
    press(4'd2);
    check("t4.chain_b", 32'(bus.disp_val), 2);
    press(KEY_EQ);
    count_busy(n_busy);
    check("t4.chain_busy", 32'(n_busy), 1);
    check_outs("t4.chain_res", 16, 0, 0, 0, 0, 0);

    // 8 / 0 -> error, digits ignored, C recovers
    press(4'd8); press(KEY_DIV); press(4'd0); press(KEY_EQ);
    count_busy(n_busy);
    check_outs("t5.err", 0, 0, 3, 0, 0, 1);
    press(4'd3);
    check_outs("t5.err_dig", 0, 0, 3, 0, 0, 1);
    press(KEY_CLR);
    check_outs("t5.clr", 0, 0, 0, 0, 0, 0);
    press(4'd7);
    check("t5.new_a", 32'(bus.disp_val), 7);

    // '=' ignored in ENTER_A, operator replacement, late operator ignored
    press(KEY_CLR); press(KEY_EQ);
    check_outs("t6.eq_in_a", 0, 0, 0, 0, 0, 0);
    press(4'd3); press(KEY_ADD); press(KEY_SUB);
    check_outs("t6.op_repl", 3, 0, 1, 1, 0, 0);
    press(4'd2); press(KEY_MUL);
    check_outs("t6.op_late", 2, 0, 1, 1, 0, 0);
    press(KEY_EQ);
    count_busy(n_busy);
    check_outs("t6.res", 1, 0, 1, 0, 0, 0);

    // C in the middle of 9999 / 1, then a fresh division must run its full length
    press(KEY_CLR);
    repeat (4) press(4'd9);
    press(KEY_DIV); press(4'd1); press(KEY_EQ);
    repeat (5) @(negedge clk);
    check("t7.busy_mid", 32'(bus.busy), 1);
    press(KEY_CLR);
    check_outs("t7.abort", 0, 0, 0, 0, 0, 0);
    press(4'd8); press(KEY_DIV); press(4'd2); press(KEY_EQ);
    count_busy(n_busy);
    check("t7.div_cycles", 32'(n_busy), 15);
    check_outs("t7.res", 4, 0, 3, 0, 0, 0);
    repeat (20) @(negedge clk);
    check_outs("t7.stable", 4, 0, 3, 0, 0, 0);

    // Asynchronous reset in the middle of operand entry
    press(KEY_CLR);
    press(4'd1); press(4'd2); press(KEY_ADD); press(4'd3);
    check_outs("t8.pre", 3, 0, 0, 1, 0, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_outs("t8.rst_async", 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    press(4'd4); press(KEY_EQ);
    check_outs("t8.after", 4, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
